// File: rtl/flag_unit_if.sv
// Bus between the ALU datapath and the flag unit: ALU result/operands in, flag word and condition out.
interface flag_unit_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OPW = 5
);
  logic [DW-1:0]  a;
  logic [DW-1:0]  b;
  logic [DW-1:0]  r;
  logic [OPW-1:0] oper;
  logic           carry;
  logic           flag_we;
  logic           psw_ld;
  logic [7:0]     psw_in;
  logic [2:0]     cc_sel;
  logic [7:0]     flag;
  logic           cond;

  modport master (
    output a, b, r, oper, carry, flag_we, psw_ld, psw_in, cc_sel,
    input  flag, cond
  );

  modport slave (
    input  a, b, r, oper, carry, flag_we, psw_ld, psw_in, cc_sel,
    output flag, cond
  );
endinterface

// File: rtl/flag_unit.sv
// Processor status flag register with branch-condition evaluation.
// Optional macro FLAG_STICKY_OVF_EN enables the sticky overflow bit flag[5].
module flag_unit #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OPW = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  flag_unit_if.slave  bus
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);

  localparam int unsigned F_C  = 0;
  localparam int unsigned F_S  = 1;
  localparam int unsigned F_Z  = 2;
  localparam int unsigned F_P  = 3;
  localparam int unsigned F_V  = 4;
  localparam int unsigned F_SV = 5;

  logic [7:0] flag_q;
  logic [7:0] flag_nxt;
  logic [7:0] cap_flags;
  logic [7:0] ld_flags;
  logic       a_msb;
  logic       b_msb;
  logic       r_msb;
  logic       ovf;
  logic       sticky_nxt;
  logic       sticky_ld;
  logic       cond_c;

  assign a_msb = bus.a[DW-1];
  assign b_msb = bus.b[DW-1];
  assign r_msb = bus.r[DW-1];

  // Signed overflow from operand/result sign bits; only ADD and SUB can overflow.
  always_comb begin
    ovf = 1'b0;
    if (bus.oper == OP_ADD) begin
      ovf = (~a_msb & ~b_msb & r_msb) | (a_msb & b_msb & ~r_msb);
    end else if (bus.oper == OP_SUB) begin
      ovf = (~a_msb & b_msb & r_msb) | (a_msb & ~b_msb & ~r_msb);
    end
  end

`ifdef FLAG_STICKY_OVF_EN
  assign sticky_nxt = flag_q[F_SV] | ovf;
  assign sticky_ld  = bus.psw_in[F_SV];
`else
  assign sticky_nxt = 1'b0;
  assign sticky_ld  = 1'b0;
`endif

  // Flag word produced by an ALU capture.
  always_comb begin
    cap_flags       = 8'h00;
    cap_flags[F_C]  = bus.carry;
    cap_flags[F_S]  = r_msb;
    cap_flags[F_Z]  = (bus.r == '0);
    cap_flags[F_P]  = ~^bus.r;
    cap_flags[F_V]  = ovf;
    cap_flags[F_SV] = sticky_nxt;
  end

  assign ld_flags = {2'b00, sticky_ld, bus.psw_in[4:0]};

  // Restore has priority over capture; otherwise hold.
  always_comb begin
    flag_nxt = flag_q;
    if (bus.psw_ld) begin
      flag_nxt = ld_flags;
    end else if (bus.flag_we) begin
      flag_nxt = cap_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 8'h00;
    end else begin
      flag_q <= flag_nxt;
    end
  end

  // Branch condition reads the registered flags only, never the pending update.
  always_comb begin
    cond_c = 1'b0;
    case (bus.cc_sel)
      3'd0:    cond_c = 1'b1;
      3'd1:    cond_c = flag_q[F_Z];
      3'd2:    cond_c = ~flag_q[F_Z];
      3'd3:    cond_c = flag_q[F_C];
      3'd4:    cond_c = ~flag_q[F_C];
      3'd5:    cond_c = flag_q[F_S];
      3'd6:    cond_c = ~flag_q[F_S];
      default: cond_c = flag_q[F_V];
    endcase
  end

  assign bus.flag = flag_q;
  assign bus.cond = cond_c;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: DW=8 and DW=16 instances against a behavioural flag model.
module tb_flag_unit;

`ifdef FLAG_STICKY_OVF_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  flag_unit_if #(.DW(8),  .OPW(5)) bus8  ();
  flag_unit_if #(.DW(16), .OPW(5)) bus16 ();

  flag_unit #(.DW(8),  .OPW(5)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  flag_unit #(.DW(16), .OPW(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  always #5 clk = ~clk;

  // Expected flags from the arithmetic meaning of each field.
  function automatic logic [7:0] model_next(
    input logic [7:0]  cur, input int dw,
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
    input logic [4:0]  op, input logic cy, input logic we, input logic ld,
    input logic [7:0]  pin);
    logic [31:0] mask;
    logic [31:0] rv;
    logic sa, sb, sr, v;
    logic [7:0] f;
    if (ld) return pin & (STK ? 8'h3F : 8'h1F);
    if (!we) return cur;
    mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 32'h1);
    rv = r & mask;
    sa = a[dw-1];
    sb = b[dw-1];
    sr = r[dw-1];
    v  = 1'b0;
    if (op == 5'd0) v = (sa == sb) && (sr != sa);
    else if (op == 5'd1) v = (sa != sb) && (sr != sa);
    f = 8'h00;
    f[0] = cy;
    f[1] = sr;
    f[2] = (rv == 32'h0);
    f[3] = (($countones(rv) % 2) == 0);
    f[4] = v;
    f[5] = STK ? (cur[5] | v) : 1'b0;
    return f;
  endfunction

  function automatic logic model_cond(input logic [7:0] f, input logic [2:0] sel);
    logic [7:0] tbl;
    tbl = {f[4], ~f[1], f[1], ~f[0], f[0], ~f[2], f[2], 1'b1};
    return tbl[sel];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  logic [7:0] exp8  = 8'h00;
  logic [7:0] exp16 = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp8  <= 8'h00;
      exp16 <= 8'h00;
    end else begin
      exp8  <= model_next(exp8, 8, 32'(bus8.a), 32'(bus8.b), 32'(bus8.r), bus8.oper,
                          bus8.carry, bus8.flag_we, bus8.psw_ld, bus8.psw_in);
      exp16 <= model_next(exp16, 16, 32'(bus16.a), 32'(bus16.b), 32'(bus16.r), bus16.oper,
                          bus16.carry, bus16.flag_we, bus16.psw_ld, bus16.psw_in);
    end
  end

  // Mid-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("flag8",  32'(bus8.flag),  32'(exp8));
    check("cond8",  32'(bus8.cond),  32'(model_cond(exp8, bus8.cc_sel)));
    check("flag16", 32'(bus16.flag), 32'(exp16));
    check("cond16", 32'(bus16.cond), 32'(model_cond(exp16, bus16.cc_sel)));
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                       input logic [4:0] op, input logic cy, input logic we,
                       input logic ld, input logic [7:0] pin);
    bus8.a = a; bus8.b = b; bus8.r = r; bus8.oper = op; bus8.carry = cy;
    bus8.flag_we = we; bus8.psw_ld = ld; bus8.psw_in = pin;
    @(posedge clk);
    #1;
    bus8.flag_we = 1'b0;
    bus8.psw_ld  = 1'b0;
  endtask

  task automatic sel_check(input logic [2:0] sel, input logic want, input string name);
    bus8.cc_sel = sel;
    #1;
    check(name, 32'(bus8.cond), 32'(want));
  endtask

  initial begin
    bus8.a = '0; bus8.b = '0; bus8.r = '0; bus8.oper = '0; bus8.carry = 1'b0;
    bus8.flag_we = 1'b0; bus8.psw_ld = 1'b0; bus8.psw_in = '0; bus8.cc_sel = '0;
    bus16.a = '0; bus16.b = '0; bus16.r = '0; bus16.oper = '0; bus16.carry = 1'b0;
    bus16.flag_we = 1'b0; bus16.psw_ld = 1'b0; bus16.psw_in = '0; bus16.cc_sel = '0;

    // Reset state and cond during reset
    #3;
    check("rst_flag", 32'(bus8.flag), 32'h00);
    sel_check(3'd0, 1'b1, "rst_cond_sel0");
    sel_check(3'd3, 1'b0, "rst_cond_sel3");
    sel_check(3'd7, 1'b0, "rst_cond_sel7");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Overflowing ADD: S and V
    drive(8'h7F, 8'h01, 8'h80, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("add_ovf", 32'(bus8.flag), STK ? 32'h32 : 32'h12);
    sel_check(3'd5, 1'b1, "add_ovf_S");
    sel_check(3'd7, 1'b1, "add_ovf_V");

    // Hold while inputs wiggle
    drive(8'h00, 8'h00, 8'h00, 5'd1, 1'b1, 1'b0, 1'b0, 8'hFF);
    drive(8'hAA, 8'h55, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("hold", 32'(bus8.flag), STK ? 32'h32 : 32'h12);

    // SUB to zero: Z and P
    drive(8'h05, 8'h05, 8'h00, 5'd1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("sub_zero", 32'(bus8.flag), STK ? 32'h2C : 32'h0C);
    sel_check(3'd1, 1'b1, "sub_zero_Z");
    sel_check(3'd2, 1'b0, "sub_zero_nZ");

    // Restore wins over capture
    drive(8'h7F, 8'h01, 8'h80, 5'd0, 1'b1, 1'b1, 1'b1, 8'hFF);
    check("ld_prio", 32'(bus8.flag), STK ? 32'h3F : 32'h1F);

    // Sticky overflow survives a clean ADD; restore clears it
    drive(8'h00, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("ld_zero", 32'(bus8.flag), 32'h00);
    drive(8'h7F, 8'h01, 8'h80, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00);
    drive(8'h01, 8'h01, 8'h02, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00);
    check("sticky_V", 32'(bus8.flag[4]), 32'h0);
    check("sticky_SV", 32'(bus8.flag[5]), 32'(STK));
    drive(8'h00, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("sticky_clr", 32'(bus8.flag), 32'h00);

    // Non-arithmetic opcode never overflows
    drive(8'h7F, 8'h01, 8'h80, 5'd2, 1'b0, 1'b1, 1'b0, 8'h00);
    check("op_other", 32'(bus8.flag), 32'h02);

    // Carry with zero result
    drive(8'hFF, 8'h01, 8'h00, 5'd0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("carry_zero", 32'(bus8.flag), 32'h0D);
    sel_check(3'd3, 1'b1, "carry_C");
    sel_check(3'd4, 1'b0, "carry_nC");
    sel_check(3'd6, 1'b1, "carry_nS");

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 60; i++) begin
      bus8.cc_sel = 3'($urandom_range(0, 7));
      drive(8'($urandom), 8'($urandom), 8'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom));
    end

    // Async reset between edges
    drive(8'h00, 8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1, 8'h3F);
    check("pre_rst", 32'(bus8.flag), STK ? 32'h3F : 32'h1F);
    rst_n = 1'b0;
    #2;
    check("async_rst", 32'(bus8.flag), 32'h00);
    #1;
    rst_n = 1'b1;

    // 16-bit instance: C, Z, P, V
    bus16.a = 16'h8000; bus16.b = 16'h8000; bus16.r = 16'h0000;
    bus16.oper = 5'd0; bus16.carry = 1'b1; bus16.flag_we = 1'b1;
    @(posedge clk);
    #1;
    bus16.flag_we = 1'b0;
    check("dw16_add", 32'(bus16.flag), STK ? 32'h3D : 32'h1D);
    bus16.cc_sel = 3'd7;
    #1;
    check("dw16_V", 32'(bus16.cond), 32'h1);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 SHALL have parameter DW, default 8: ALU operand/result width, legal range 4..32.
REQ-002 SHALL have parameter OPW, default 5: opcode width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port a, input, DW: ALU operand A.
REQ-006 SHALL have port b, input, DW: ALU operand B.
REQ-007 SHALL have port r, input, DW: ALU result.
REQ-008 SHALL have port oper, input, OPW: ALU opcode; ADD = 0, SUB = 1.
REQ-009 SHALL have port carry, input, 1: ALU carry/borrow out.
REQ-010 SHALL have port flag_we, input, 1: capture new flags from the current ALU result.
REQ-011 SHALL have port psw_ld, input, 1: load the flag register from psw_in (flag restore).
REQ-012 SHALL have port psw_in, input, 8: restore value.
REQ-013 SHALL have port cc_sel, input, 3: branch condition select.
REQ-014 SHALL have port flag, output, 8: registered flag word.
REQ-015 SHALL have port cond, output, 1: evaluated branch condition.

Function
REQ-016 SHALL keep flag bit map fixed: [0] C, [1] S, [2] Z, [3] P (even parity), [4] V, [5] sticky V, [6] and [7] always 0.
REQ-017 SHALL, on a flag_we capture, load C=carry, S=r[DW-1], Z=(r==0), P=XNOR-reduction of all DW bits of r, and V as defined in REQ-018.
REQ-018 SHALL compute V as follows: ADD: (~a[DW-1]&~b[DW-1]&r[DW-1])|(a[DW-1]&b[DW-1]&~r[DW-1]); SUB: (~a[DW-1]&b[DW-1]&r[DW-1])|(a[DW-1]&~b[DW-1]&~r[DW-1]); any other opcode: 0.
REQ-019 SHALL apply update priority per edge: psw_ld > flag_we > hold.
REQ-020 SHALL, on psw_ld, set flag = {2'b00, psw_in[5:0]}, with bits 7:6 forced to 0.
REQ-021 SHALL, when flag_we=0 and psw_ld=0, hold all flags unchanged, whatever a, b, r, oper or carry do.
REQ-022 SHALL give one-cycle capture latency: values present at edge N are visible on flag after edge N.
REQ-023 SHALL derive cond combinationally from registered flags: cc_sel 0 -> 1; 1 -> Z; 2 -> ~Z; 3 -> C; 4 -> ~C; 5 -> S; 6 -> ~S; 7 -> V.
REQ-024 SHALL evaluate cond on the pre-update flag value in the same cycle that flag_we is asserted, with no bypass.

Reset
REQ-025 SHALL, while rst_n=0, force flag=8'h00 immediately, independent of clk.
REQ-026 SHALL give the first capture after rst_n deasserts the same behaviour as any other capture; reset mid-sequence discards sticky state.
REQ-027 SHALL drive cond=1 during reset when cc_sel=0 and 0 for all other selects, because it derives from the cleared flags.

Configuration
REQ-028 SHALL, with macro FLAG_STICKY_OVF_EN defined, update flag[5] on each capture as flag[5] | V; flag[5] clears only via reset or psw_ld.
REQ-029 SHALL, without FLAG_STICKY_OVF_EN, hold flag[5] at 0 permanently, so psw_in[5] is ignored on load.

Verification
REQ-030 SHALL cover: DW=8, ADD, a=8'h7F, b=8'h01, r=8'h80, carry=0, flag_we=1 -> flag=8'h12 (S, V; P=0); with STICKY_OVF_EN, flag=8'h32.
REQ-031 SHALL cover: SUB, a=8'h05, b=8'h05, r=8'h00, carry=0, flag_we=1 -> flag=8'h0C (Z, P), then cc_sel=1 -> cond=1 and cc_sel=2 -> cond=0.
REQ-032 SHALL cover: flag_we and psw_ld both 1 with psw_in=8'hFF -> flag=8'h3F with STICKY_OVF_EN, 8'h1F without.
REQ-033 SHALL cover: with STICKY_OVF_EN, an overflowing ADD followed by a non-overflowing ADD -> flag[4]=0 and flag[5]=1; then psw_ld with psw_in=0 -> flag=8'h00.
REQ-034 SHALL cover: rst_n pulsed low between clock edges with flag=8'h3F -> flag=8'h00 before the next edge.
REQ-035 SHALL cover: DW=16, ADD, a=16'h8000, b=16'h8000, r=16'h0000, carry=1 -> flag=8'h1D (C, Z, P, V).
